// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receive and transmit blocks.
//   UART_DATA_W       : payload bits per frame (8N1)
//   UART_CLKS_PER_BIT : default clocks per serial bit, common to uart_tx/uart_rx
//   rx_state_t        : receiver FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// Multi-flop synchronizer for an asynchronous single-bit input. The chain
// resets to 1 so an idle-high serial line does not look like a start bit
// straight out of reset.
// Ports:
//   clk  : input  clock
//   rst  : input  synchronous active-high reset (chain -> all ones)
//   d    : input  asynchronous signal
//   q    : output synchronized signal, STAGES clocks behind d
// ---------------------------------------------------------------------------
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; the first stage
    // may go metastable, the later stages give it time to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with mid-bit sampling, valid/ready output, framing
// error pulse and sticky overrun flag.
// Ports:
//   rx_clk          : input  clock, all logic on the rising edge
//   rx_rst          : input  synchronous active-high reset
//   rx_en           : input  receiver enable; low aborts a frame in progress
//   rx_i            : input  asynchronous serial line, idles high
//   rx_o_data       : output received byte, LSB received first
//   rx_o_data_valid : output rx_o_data holds an unconsumed byte
//   rx_i_ready      : input  consumer accepts the byte when valid is high
//   rx_o_frame_err  : output one-cycle pulse, stop bit sampled low
//   rx_o_overrun    : output sticky, a completed byte was dropped
//   rx_o_busy       : output FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst,
    input  logic                   rx_en,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] rx_o_data,
    output logic                   rx_o_data_valid,
    input  logic                   rx_i_ready,
    output logic                   rx_o_frame_err,
    output logic                   rx_o_overrun,
    output logic                   rx_o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t              state;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   rxs;
    logic                   handshake;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (rx_clk),
        .rst (rx_rst),
        .d   (rx_i),
        .q   (rxs)
    );

    assign handshake = rx_o_data_valid & rx_i_ready;

    // Receiver FSM. Walks through start, data and stop bits sampling the
    // synchronized line in the middle of each bit. The output register is
    // only written on a good stop bit; a handshake on the same edge frees the
    // slot so the new byte can be loaded without flagging an overrun.
    // Disabling the receiver drops the partial frame and clears the overrun
    // flag but leaves any pending byte available to the consumer.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            rx_o_data       <= '0;
            rx_o_data_valid <= 1'b0;
            rx_o_frame_err  <= 1'b0;
            rx_o_overrun    <= 1'b0;
            rx_o_busy       <= 1'b0;
        end else begin
            rx_o_frame_err <= 1'b0;
            if (handshake) begin
                rx_o_data_valid <= 1'b0;
            end

            if (!rx_en) begin
                state        <= IDLE;
                clk_cnt      <= '0;
                bit_idx      <= '0;
                rx_o_overrun <= 1'b0;
                rx_o_busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state     <= START;
                            clk_cnt   <= '0;
                            rx_o_busy <= 1'b1;
                        end
                    end

                    START: begin
                        if (clk_cnt == HALF_LAST) begin
                            clk_cnt <= '0;
                            if (!rxs) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state     <= IDLE;
                                rx_o_busy <= 1'b0;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + CNT_W'(1);
                        end
                    end

                    DATA: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            shreg   <= {rxs, shreg[UART_DATA_W-1:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + CNT_W'(1);
                        end
                    end

                    STOP: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            if (rxs) begin
                                state     <= IDLE;
                                rx_o_busy <= 1'b0;
                                if (!rx_o_data_valid || handshake) begin
                                    rx_o_data       <= shreg;
                                    rx_o_data_valid <= 1'b1;
                                end else begin
                                    rx_o_overrun <= 1'b1;
                                end
                            end else begin
                                state          <= WAIT_IDLE;
                                rx_o_frame_err <= 1'b1;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + CNT_W'(1);
                        end
                    end

                    WAIT_IDLE: begin
                        if (rxs) begin
                            state     <= IDLE;
                            rx_o_busy <= 1'b0;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        clk_cnt   <= '0;
                        rx_o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx with default parameters
// (16 clocks per bit, 2 synchronizer stages). A behavioural 8N1 transmitter
// drives rx_i; a negedge monitor records valid rises, received bytes and
// error pulses so each scenario can compare counts and values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       rx_clk = 1'b0;
    logic       rx_rst;
    logic       rx_en;
    logic       rx_i;
    logic [7:0] rx_o_data;
    logic       rx_o_data_valid;
    logic       rx_i_ready;
    logic       rx_o_frame_err;
    logic       rx_o_overrun;
    logic       rx_o_busy;

    int checks = 0;
    int fails  = 0;

    int         cyc        = 0;
    int         riseCount  = 0;
    int         riseCyc    = 0;
    int         highCount  = 0;
    int         errHigh    = 0;
    int         errPulses  = 0;
    logic       prevValid  = 1'b0;
    logic       prevErr    = 1'b0;
    logic [7:0] rxLog[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .rx_clk          (rx_clk),
        .rx_rst          (rx_rst),
        .rx_en           (rx_en),
        .rx_i            (rx_i),
        .rx_o_data       (rx_o_data),
        .rx_o_data_valid (rx_o_data_valid),
        .rx_i_ready      (rx_i_ready),
        .rx_o_frame_err  (rx_o_frame_err),
        .rx_o_overrun    (rx_o_overrun),
        .rx_o_busy       (rx_o_busy)
    );

    // 10 ns clock period.
    always #5 rx_clk = ~rx_clk;

    // Count rising edges so latencies can be measured from the frame start.
    always @(posedge rx_clk) begin
        cyc <= cyc + 1;
    end

    // Output monitor, sampled mid-cycle: logs each valid rise with the byte
    // it presented, and counts valid-high cycles and frame error pulses.
    always @(negedge rx_clk) begin
        prevValid <= rx_o_data_valid;
        prevErr   <= rx_o_frame_err;
        if (rx_o_data_valid === 1'b1 && prevValid !== 1'b1) begin
            riseCount <= riseCount + 1;
            riseCyc   <= cyc;
            rxLog.push_back(rx_o_data);
        end
        if (rx_o_data_valid === 1'b1) begin
            highCount <= highCount + 1;
        end
        if (rx_o_frame_err === 1'b1) begin
            errHigh <= errHigh + 1;
        end
        if (rx_o_frame_err === 1'b1 && prevErr !== 1'b1) begin
            errPulses <= errPulses + 1;
        end
    end

    // Behavioural transmitter: start bit, 8 data bits LSB first, then the
    // stop level for stopBits bit-times, leaving the line high. Called on a
    // negedge; the following rising edge is cycle 0 of the frame.
    task automatic applyStimulus(input logic [7:0] b, input logic stopVal,
                                 input int stopBits);
        rx_i = 1'b0;
        repeat (CPB) @(negedge rx_clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge rx_clk);
        end
        rx_i = stopVal;
        repeat (CPB * stopBits) @(negedge rx_clk);
        rx_i = 1'b1;
    endtask

    // Reset values while reset is held and just after release.
    task automatic test_reset();
        rx_rst     = 1'b1;
        rx_en      = 1'b1;
        rx_i       = 1'b1;
        rx_i_ready = 1'b0;
        repeat (3) @(negedge rx_clk);
        checks++;
        if (rx_o_data !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h expected 00", rx_o_data);
        end
        checks++;
        if (rx_o_data_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_valid: got %b expected 0", rx_o_data_valid);
        end
        checks++;
        if (rx_o_frame_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_o_frame_err);
        end
        checks++;
        if (rx_o_overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_overrun: got %b expected 0", rx_o_overrun);
        end
        rx_rst = 1'b0;
        repeat (4) @(negedge rx_clk);
        checks++;
        if (rx_o_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_busy: got %b expected 0", rx_o_busy);
        end
    endtask

    // Single frame A5 with ready high: one-cycle valid at cycle 155.
    task automatic test_basic();
        int r0, h0, e0, startCyc;
        rx_i_ready = 1'b1;
        r0 = riseCount;
        h0 = highCount;
        e0 = errHigh;
        startCyc = cyc;
        applyStimulus(8'hA5, 1'b1, 1);
        repeat (20) @(negedge rx_clk);
        checks++;
        if (riseCount - r0 !== 1) begin
            fails++;
            $display("[TB] FAIL basic_rises: got %0d expected 1", riseCount - r0);
        end
        checks++;
        if (riseCyc - startCyc !== 155) begin
            fails++;
            $display("[TB] FAIL basic_latency: got %0d expected 155", riseCyc - startCyc);
        end
        checks++;
        if (rxLog[$] !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL basic_data: got %h expected a5", rxLog[$]);
        end
        checks++;
        if (highCount - h0 !== 1) begin
            fails++;
            $display("[TB] FAIL basic_valid_width: got %0d expected 1", highCount - h0);
        end
        checks++;
        if (errHigh - e0 !== 0 || rx_o_overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_flags: err %0d ovr %b expected 0 0",
                     errHigh - e0, rx_o_overrun);
        end
        checks++;
        if (rx_o_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_busy: got %b expected 0", rx_o_busy);
        end
    endtask

    // Two frames with ready low: first byte held, second dropped as overrun.
    task automatic test_back_to_back();
        int r0;
        rx_i_ready = 1'b0;
        r0 = riseCount;
        applyStimulus(8'h3C, 1'b1, 1);
        applyStimulus(8'hC3, 1'b1, 1);
        repeat (4) @(negedge rx_clk);
        checks++;
        if (rx_o_data !== 8'h3C || rx_o_data_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_hold: got %h/%b expected 3c/1",
                     rx_o_data, rx_o_data_valid);
        end
        checks++;
        if (rx_o_overrun !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_overrun: got %b expected 1", rx_o_overrun);
        end
        checks++;
        if (riseCount - r0 !== 1) begin
            fails++;
            $display("[TB] FAIL b2b_rises: got %0d expected 1", riseCount - r0);
        end
        rx_i_ready = 1'b1;
        @(negedge rx_clk);
        rx_i_ready = 1'b0;
        @(negedge rx_clk);
        checks++;
        if (rx_o_data_valid !== 1'b0 || rx_o_overrun !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_after_hs: valid %b ovr %b expected 0 1",
                     rx_o_data_valid, rx_o_overrun);
        end
        rx_en = 1'b0;
        @(negedge rx_clk);
        rx_en = 1'b1;
        checks++;
        if (rx_o_overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_ovr_clear: got %b expected 0", rx_o_overrun);
        end
        repeat (4) @(negedge rx_clk);
    endtask

    // Stop bit held low for two bit-times, then a clean 0F frame.
    task automatic test_frame_error();
        int r0, e0, p0;
        rx_i_ready = 1'b1;
        r0 = riseCount;
        e0 = errHigh;
        p0 = errPulses;
        applyStimulus(8'h55, 1'b0, 2);
        checks++;
        if (rx_o_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ferr_wait_idle_busy: got %b expected 1", rx_o_busy);
        end
        repeat (CPB) @(negedge rx_clk);
        applyStimulus(8'h0F, 1'b1, 1);
        repeat (20) @(negedge rx_clk);
        checks++;
        if (errHigh - e0 !== 1 || errPulses - p0 !== 1) begin
            fails++;
            $display("[TB] FAIL ferr_pulse: cycles %0d pulses %0d expected 1 1",
                     errHigh - e0, errPulses - p0);
        end
        checks++;
        if (riseCount - r0 !== 1) begin
            fails++;
            $display("[TB] FAIL ferr_rises: got %0d expected 1", riseCount - r0);
        end
        checks++;
        if (rxLog[$] !== 8'h0F) begin
            fails++;
            $display("[TB] FAIL ferr_next_data: got %h expected 0f", rxLog[$]);
        end
    endtask

    // Four-clock low pulse: enters START, rejected at mid start bit.
    task automatic test_glitch();
        int r0, e0;
        r0 = riseCount;
        e0 = errHigh;
        rx_i = 1'b0;
        repeat (4) @(negedge rx_clk);
        rx_i = 1'b1;
        checks++;
        if (rx_o_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL glitch_busy_start: got %b expected 1", rx_o_busy);
        end
        repeat (20) @(negedge rx_clk);
        checks++;
        if (rx_o_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL glitch_busy_end: got %b expected 0", rx_o_busy);
        end
        checks++;
        if (riseCount - r0 !== 0 || errHigh - e0 !== 0) begin
            fails++;
            $display("[TB] FAIL glitch_quiet: rises %0d err %0d expected 0 0",
                     riseCount - r0, errHigh - e0);
        end
    endtask

    // Disable mid-DATA; only the following 19 frame is delivered.
    task automatic test_abort();
        int r0;
        rx_i_ready = 1'b1;
        r0 = riseCount;
        fork
            applyStimulus(8'h6E, 1'b1, 1);
            begin
                repeat (60) @(negedge rx_clk);
                rx_en = 1'b0;
                @(negedge rx_clk);
                checks++;
                if (rx_o_busy !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL abort_busy: got %b expected 0", rx_o_busy);
                end
            end
        join
        repeat (4) @(negedge rx_clk);
        rx_en = 1'b1;
        @(negedge rx_clk);
        applyStimulus(8'h19, 1'b1, 1);
        repeat (20) @(negedge rx_clk);
        checks++;
        if (riseCount - r0 !== 1 || rxLog[$] !== 8'h19) begin
            fails++;
            $display("[TB] FAIL abort_data: rises %0d last %h expected 1 19",
                     riseCount - r0, rxLog[$]);
        end
    endtask

    // Back-to-back AA then 19 as a transmitter would send them.
    task automatic test_loopback();
        int r0;
        rx_i_ready = 1'b1;
        r0 = riseCount;
        applyStimulus(8'hAA, 1'b1, 1);
        applyStimulus(8'h19, 1'b1, 1);
        repeat (20) @(negedge rx_clk);
        checks++;
        if (riseCount - r0 !== 2) begin
            fails++;
            $display("[TB] FAIL loop_rises: got %0d expected 2", riseCount - r0);
        end
        checks++;
        if (rxLog[$-1] !== 8'hAA || rxLog[$] !== 8'h19) begin
            fails++;
            $display("[TB] FAIL loop_order: got %h %h expected aa 19",
                     rxLog[$-1], rxLog[$]);
        end
    endtask

    // Reset pulse during DATA with a pending byte, then a clean 42 frame.
    task automatic test_reset_mid();
        int r0;
        rx_i_ready = 1'b0;
        applyStimulus(8'h5A, 1'b1, 1);
        repeat (4) @(negedge rx_clk);
        checks++;
        if (rx_o_data_valid !== 1'b1 || rx_o_data !== 8'h5A) begin
            fails++;
            $display("[TB] FAIL rstmid_pending: got %b/%h expected 1/5a",
                     rx_o_data_valid, rx_o_data);
        end
        fork
            applyStimulus(8'hFD, 1'b1, 1);
            begin
                repeat (60) @(negedge rx_clk);
                rx_rst = 1'b1;
                @(negedge rx_clk);
                rx_rst = 1'b0;
                checks++;
                if (rx_o_data !== 8'h00 || rx_o_data_valid !== 1'b0 ||
                    rx_o_busy !== 1'b0 || rx_o_overrun !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL rstmid_values: data %h valid %b busy %b ovr %b expected 00 0 0 0",
                             rx_o_data, rx_o_data_valid, rx_o_busy, rx_o_overrun);
                end
            end
        join
        repeat (20) @(negedge rx_clk);
        checks++;
        if (rx_o_data_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rstmid_no_ghost: got %b expected 0", rx_o_data_valid);
        end
        rx_i_ready = 1'b1;
        r0 = riseCount;
        applyStimulus(8'h42, 1'b1, 1);
        repeat (20) @(negedge rx_clk);
        checks++;
        if (riseCount - r0 !== 1 || rxLog[$] !== 8'h42) begin
            fails++;
            $display("[TB] FAIL rstmid_next: rises %0d last %h expected 1 42",
                     riseCount - r0, rxLog[$]);
        end
    endtask

    // Scenario sequence.
    initial begin
        rx_rst     = 1'b1;
        rx_en      = 1'b0;
        rx_i       = 1'b1;
        rx_i_ready = 1'b0;
        @(negedge rx_clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_abort();
        test_loopback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
